// File: rtl/ipv4_rx.sv
// Receive-side IPv4 layer: parses and strips the 20-byte header of each frame,
// filters unwanted datagrams and forwards the payload with a checksum flag.
module ipv4_rx #(
  parameter int              DATA_W = 16,
  parameter int              LEN_W  = $clog2(DATA_W/8) + 1,
  parameter int              IP_W   = 32,
  parameter logic [IP_W-1:0] DST_IP = 32'hC0A8_0102,
  parameter logic [7:0]      PROTO  = 8'd17
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              cancel_o,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              ip_cs_err_o
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    DATA = 4'b0100,
    DROP = 4'b1000
  } state_t;

  localparam logic [15:0] HDR_BYTES = 16'd20;

  // Ones-complement add with the end-around carry folded straight back in.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    logic [16:0] sum;
    sum = {1'b0, acc} + {1'b0, word};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  state_t      state_r;
  logic [3:0]  beat_cnt_r;
  logic [15:0] csum_r;
  logic [15:0] total_len_r;
  logic [15:0] remain_r;
  logic        drop_r;
  logic        cs_err_r;
  logic        first_r;

  logic [15:0]      word_s;
  logic [15:0]      csum_nxt_s;
  logic [15:0]      len_ext_s;
  logic [15:0]      len_eff_ext_s;
  logic [LEN_W-1:0] len_eff_s;
  logic             hdr0_bad_s;
  logic             field_bad_s;
  logic             drop_nxt_s;
  logic             data_beat_s;

  // Header words arrive with the earlier wire byte low; swap to network order.
  assign word_s        = {data_i[7:0], data_i[15:8]};
  assign csum_nxt_s    = csum_add(csum_r, word_s);
  assign hdr0_bad_s    = (data_i[7:0] != 8'h45) | (len_i != LEN_W'(2));
  assign drop_nxt_s    = drop_r | field_bad_s | (len_i != LEN_W'(2));
  assign len_ext_s     = {{(16-LEN_W){1'b0}}, len_i};
  assign len_eff_s     = (remain_r < len_ext_s) ? remain_r[LEN_W-1:0] : len_i;
  assign len_eff_ext_s = {{(16-LEN_W){1'b0}}, len_eff_s};

  // Per-word header filter checks, selected by the word index.
  always_comb begin
    field_bad_s = 1'b0;
    case (beat_cnt_r)
      4'd1:    field_bad_s = (word_s < HDR_BYTES);
      4'd3:    field_bad_s = data_i[5] | (data_i[4:0] != 5'd0) | (data_i[15:8] != 8'd0);
      4'd4:    field_bad_s = (data_i[15:8] != PROTO);
      4'd8:    field_bad_s = (word_s != DST_IP[31:16]);
      4'd9:    field_bad_s = (word_s != DST_IP[15:0]);
      default: field_bad_s = 1'b0;
    endcase
  end

  // A new start or a cancel preempts the payload beat; zero-length beats are never shown.
  assign data_beat_s = (state_r == DATA) & valid_i & ~start_i & ~cancel_i & (len_eff_s != {LEN_W{1'b0}});
  assign valid_o     = data_beat_s;
  assign start_o     = data_beat_s & first_r;
  assign data_o      = data_beat_s ? data_i : {DATA_W{1'b0}};
  assign len_o       = data_beat_s ? len_eff_s : {LEN_W{1'b0}};
  assign ip_cs_err_o = data_beat_s & cs_err_r;
  assign cancel_o    = (state_r == DATA) &
                       (cancel_i | (valid_i & start_i & (remain_r != 16'd0)));

  // Frame parser state machine; header decode and payload bookkeeping.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= IDLE;
      beat_cnt_r  <= 4'd0;
      csum_r      <= 16'd0;
      total_len_r <= 16'd0;
      remain_r    <= 16'd0;
      drop_r      <= 1'b0;
      cs_err_r    <= 1'b0;
      first_r     <= 1'b0;
    end else if (cancel_i) begin
      state_r <= IDLE;
      drop_r  <= 1'b0;
      first_r <= 1'b0;
    end else if (valid_i & start_i) begin
      state_r    <= HEAD;
      beat_cnt_r <= 4'd1;
      csum_r     <= word_s;
      drop_r     <= hdr0_bad_s;
      cs_err_r   <= 1'b0;
      first_r    <= 1'b0;
    end else if (valid_i) begin
      case (state_r)
        HEAD: begin
          beat_cnt_r <= beat_cnt_r + 4'd1;
          csum_r     <= csum_nxt_s;
          drop_r     <= drop_nxt_s;
          if (beat_cnt_r == 4'd1) begin
            total_len_r <= word_s;
          end
          if (beat_cnt_r == 4'd9) begin
            cs_err_r <= (csum_nxt_s != 16'hFFFF);
            if (drop_nxt_s) begin
              state_r <= DROP;
            end else if (total_len_r == HDR_BYTES) begin
              state_r <= IDLE;
            end else begin
              state_r  <= DATA;
              remain_r <= total_len_r - HDR_BYTES;
              first_r  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (data_beat_s) begin
            remain_r <= remain_r - len_eff_ext_s;
            first_r  <= 1'b0;
            if (remain_r == len_eff_ext_s) begin
              state_r <= DROP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_rx.sv
// Bench for ipv4_rx: builds byte-level frames, predicts the forwarded payload from
// the header fields and byte positions, and checks every beat.
module tb_ipv4_rx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cancel_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_i = 16'd0;
  logic [1:0]  len_i = 2'd0;
  logic        cancel_o, valid_o, start_o, ip_cs_err_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;

  ipv4_rx dut (
    .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
    .start_i(start_i), .data_i(data_i), .len_i(len_i), .cancel_o(cancel_o),
    .valid_o(valid_o), .start_o(start_o), .data_o(data_o), .len_o(len_o),
    .ip_cs_err_o(ip_cs_err_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] frm [256];
  int         frm_len;
  logic       exp_cancel_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_cancel"}, 32'(cancel_o), 32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_len"}, 32'(len_o), 32'd0);
    chk({tag, "_cserr"}, 32'(ip_cs_err_o), 32'd0);
  endtask

  task automatic build(input logic [7:0] b0, input logic [15:0] tlen, input logic [7:0] proto,
                       input logic [31:0] dst, input logic [15:0] frag, input logic cs_flip,
                       input int extra);
    int          sum;
    logic [15:0] cs;
    frm_len = ((int'(tlen) > 46) ? int'(tlen) : 46) + extra;
    for (int i = 0; i < 256; i++) frm[i] = 8'($urandom);
    frm[0] = b0;           frm[1] = 8'h00;
    frm[2] = tlen[15:8];   frm[3] = tlen[7:0];
    frm[6] = frag[15:8];   frm[7] = frag[7:0];
    frm[8] = 8'd64;        frm[9] = proto;
    frm[10] = 8'd0;        frm[11] = 8'd0;
    frm[16] = dst[31:24];  frm[17] = dst[23:16];
    frm[18] = dst[15:8];   frm[19] = dst[7:0];
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'({frm[2*i], frm[2*i+1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
    cs = ~sum[15:0];
    frm[10] = cs[15:8] ^ {7'd0, cs_flip};
    frm[11] = cs[7:0];
  endtask

  // Drives the current frame; trunc limits the beats sent, cancel_beat raises cancel_i.
  task automatic send_frame(input int trunc, input int cancel_beat, input int gap_pct);
    int          nbeats, tl, pos, blen, exp_len, sum;
    logic        hdr_ok, cs_bad, first_seen, cancelled, exp_cancel;
    logic [15:0] beat;
    tl = int'({frm[2], frm[3]});
    hdr_ok = (frm[0] == 8'h45) && (tl >= 20) && !frm[6][5] &&
             ({frm[6][4:0], frm[7]} == 13'd0) && (frm[9] == 8'd17) &&
             ({frm[16], frm[17], frm[18], frm[19]} == 32'hC0A8_0102);
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'({frm[2*i], frm[2*i+1]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
    cs_bad = (sum != 32'hFFFF);
    nbeats = (frm_len + 1) / 2;
    if (trunc >= 0 && trunc < nbeats) nbeats = trunc;
    first_seen = 1'b0;
    cancelled = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);
        chk("gap_valid", 32'(valid_o), 32'd0);
        chk("gap_cancel", 32'(cancel_o), 32'd0);
        @(posedge clk); #1;
      end
      pos  = 2 * b;
      blen = (frm_len - pos >= 2) ? 2 : 1;
      beat = {frm[pos+1], frm[pos]};
      valid_i  = 1'b1;
      start_i  = (b == 0);
      cancel_i = (b == cancel_beat);
      data_i   = beat;
      len_i    = 2'(blen);
      if (b == 0) begin
        exp_cancel = exp_cancel_next;
        exp_cancel_next = 1'b0;
      end else if (b == cancel_beat) begin
        exp_cancel = !cancelled && hdr_ok && b >= 10 && pos < tl;
      end else begin
        exp_cancel = 1'b0;
      end
      exp_len = 0;
      if (!cancelled && b != cancel_beat && hdr_ok && b >= 10 && pos < tl)
        exp_len = (tl - pos < blen) ? tl - pos : blen;
      @(negedge clk);
      chk("cancel_o", 32'(cancel_o), 32'(exp_cancel));
      if (b != cancel_beat) begin
        chk("valid_o", 32'(valid_o), 32'(exp_len != 0));
        if (exp_len != 0) begin
          chk("len_o", 32'(len_o), 32'(exp_len));
          chk("data_o", 32'(data_o), 32'(beat));
          chk("start_o", 32'(start_o), 32'(!first_seen));
          chk("ip_cs_err_o", 32'(ip_cs_err_o), 32'(cs_bad));
          first_seen = 1'b1;
        end
      end
      if (b == cancel_beat) cancelled = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
    exp_cancel_next = !cancelled && hdr_ok && nbeats >= 10 && 2 * nbeats < tl;
  endtask

  task automatic pulse_reset();
    nreset = 1'b0; valid_i = 1'b1; start_i = 1'b0; cancel_i = 1'b1;
    data_i = 16'h1234; len_i = 2'd2;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    chk_all_zero("rst_held");
    @(posedge clk); #1;
    nreset = 1'b1; valid_i = 1'b0; cancel_i = 1'b0;
    exp_cancel_next = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] GOOD_IP = 32'hC0A8_0102;

  initial begin
    int r, tl, trunc, cb;
    logic [7:0]  b0, pr;
    logic [31:0] ip;
    logic [15:0] fr;
    logic        flip;

    // Reset state.
    @(posedge clk); #1;
    pulse_reset();
    chk_all_zero("post_reset");

    // Good frame, 10-byte payload.
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    // Odd payload with padding.
    build(8'h45, 16'h001D, 8'd17, GOOD_IP, 16'h4000, 1'b0, 0);
    send_frame(-1, -1, 0);
    // Bad checksum still forwards.
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b1, 0);
    send_frame(-1, -1, 0);
    // Filter drops.
    build(8'h45, 16'h001E, 8'd6, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    build(8'h45, 16'h001E, 8'd17, 32'hC0A8_0103, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    build(8'h46, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h2000, 1'b0, 0);
    send_frame(-1, -1, 0);
    build(8'h45, 16'h0010, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    // Empty payload.
    build(8'h45, 16'h0014, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    // Cancel on payload beat 3, then a normal frame.
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, 12, 0);
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);
    // New start with four payload bytes outstanding.
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(13, -1, 0);
    build(8'h45, 16'h0021, 8'd17, GOOD_IP, 16'h0000, 1'b0, 1);
    send_frame(-1, -1, 0);
    // Reset in the middle of a header.
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(5, -1, 0);
    pulse_reset();
    build(8'h45, 16'h001E, 8'd17, GOOD_IP, 16'h0000, 1'b0, 0);
    send_frame(-1, -1, 0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      r    = int'($urandom_range(0, 11));
      b0   = (r == 6) ? 8'h44 : 8'h45;
      pr   = (r == 7) ? 8'd6 : 8'd17;
      ip   = (r == 8) ? (GOOD_IP ^ (32'd1 << $urandom_range(0, 31))) : GOOD_IP;
      fr   = (r == 9) ? 16'(1 + $urandom_range(0, 8190)) : ((r == 10) ? 16'h2000 : 16'h4000);
      flip = (r == 11);
      tl   = int'($urandom_range(16, 90));
      build(b0, 16'(tl), pr, ip, fr, flip, int'($urandom_range(0, 3)));
      trunc = -1;
      cb = -1;
      case ($urandom_range(0, 3))
        0: trunc = int'($urandom_range(1, (frm_len + 1) / 2));
        1: cb = int'($urandom_range(1, (frm_len + 1) / 2 - 1));
        default: begin end
      endcase
      send_frame(trunc, cb, 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
